// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : funct3 encodings, FSM states and access legality check for the LSU
// rev 1.0
// ============================================================================
package lsu_pkg;

  localparam int LSU_W = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Stores have no unsigned variants, so any funct3[2]=1 store is illegal.
  function automatic logic lsu_access_err(input logic       store,
                                          input logic [2:0] f3,
                                          input logic [2:0] off);
    logic illegal;
    logic misaligned;
    illegal = store ? f3[2] : (f3 == 3'b111);
    unique case (f3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
    return illegal | misaligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// lsu_lane : byte enables, load extract/extend and store merge for one word
// rev 1.0
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [2:0]       offset_i,
  input  logic [LSU_W-1:0] mem_word_i,
  input  logic [LSU_W-1:0] wdata_i,
  output logic [LSU_W-1:0] load_data_o,
  output logic [LSU_W-1:0] merged_o
);

  logic [7:0]       be;
  logic [LSU_W-1:0] rshift;
  logic [LSU_W-1:0] wshift;
  logic             sx;

  assign rshift = mem_word_i >> {offset_i, 3'b000};
  assign wshift = wdata_i << {offset_i, 3'b000};
  assign sx     = ~funct3_i[2];

  always_comb begin
    be = 8'h00;
    unique case (funct3_i[1:0])
      2'd0:    be = 8'h01 << offset_i;
      2'd1:    be = 8'h03 << offset_i;
      2'd2:    be = 8'h0F << offset_i;
      default: be = 8'hFF;
    endcase
  end

  always_comb begin
    load_data_o = '0;
    unique case (funct3_i[1:0])
      2'd0:    load_data_o = {{56{sx & rshift[7]}},  rshift[7:0]};
      2'd1:    load_data_o = {{48{sx & rshift[15]}}, rshift[15:0]};
      2'd2:    load_data_o = {{32{sx & rshift[31]}}, rshift[31:0]};
      default: load_data_o = rshift;
    endcase
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign merged_o[8*k +: 8] = be[k] ? wshift[8*k +: 8] : mem_word_i[8*k +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : core-to-memory bridge, sub-word stores done as read-modify-write
// rev 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE = 64,
  parameter int N    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   store_i,
  input  logic [2:0]             funct3_i,
  input  logic [$clog2(N)+2:0]   addr_i,
  input  logic [SIZE-1:0]        wdata_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [SIZE-1:0]        rdata_o,
  output logic [$clog2(N)-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [SIZE-1:0]        mem_din_o,
  input  logic [SIZE-1:0]        mem_dout_i
);

  localparam int AW = $clog2(N);

  lsu_state_e      state_q;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [2:0]      off_q;
  logic [SIZE-1:0] wdata_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;
  logic [SIZE-1:0] rdata_q;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_we_q;
  logic [SIZE-1:0] mem_din_q;

  logic [SIZE-1:0] load_w;
  logic [SIZE-1:0] merged_w;

  lsu_lane u_lane (
    .funct3_i    (funct3_q),
    .offset_i    (off_q),
    .mem_word_i  (mem_dout_i),
    .wdata_i     (wdata_q),
    .load_data_o (load_w),
    .merged_o    (merged_w)
  );

  // mem_din_q doubles as the merge register: it holds SD data or the RMW word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 3'b000;
      wdata_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            store_q  <= store_i;
            funct3_q <= funct3_i;
            off_q    <= addr_i[2:0];
            wdata_q  <= wdata_i;
            ready_q  <= 1'b0;
            if (lsu_access_err(store_i, funct3_i, addr_i[2:0])) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              err_q      <= 1'b0;
              mem_addr_q <= addr_i[AW+2:3];
              if (store_i && (funct3_i == F3_D)) begin
                mem_we_q  <= 1'b1;
                mem_din_q <= wdata_i;
              end
            end
          end
        end
        ACCESS: begin
          if (!store_q) begin
            rdata_q <= load_w;
            state_q <= RESP;
            done_q  <= 1'b1;
          end else if (funct3_q == F3_D) begin
            state_q <= RESP;
            done_q  <= 1'b1;
          end else begin
            mem_din_q <= merged_w;
            mem_we_q  <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_we_o   = mem_we_q;
  assign mem_din_o  = mem_din_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side bridge between the core's memory stage and the single-port data memory (synchronous write, combinational read, full-word write enable only). It accepts one byte-addressed load or store at a time from the core using RISC-V funct3 encodings. It performs aligned byte, half, word and doubleword accesses, with sign or zero extension on loads. Because the memory can only write whole words, sub-word stores are done as a read-modify-write.

## Interface
- SIZE, 64, memory word width in bits (fixed at 64; the lane logic assumes 8 byte lanes)
- N, 32, number of memory words
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  1  core request; accepted only when READY=1
- STORE  in  1  1=store, 0=load; sampled with REQ
- FUNCT3  in  3  access type; sampled with REQ
- ADDR  in  $clog2(N)+3  byte address; sampled with REQ
- WDATA  in  SIZE  store data, right-aligned; sampled with REQ
- READY  out  1  unit idle, can accept REQ
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; misaligned access or illegal FUNCT3
- RDATA  out  SIZE  extended load result; valid with DONE, held until the next DONE
- MEM_ADDR  out  $clog2(N)  word address to memory
- MEM_WE  out  1  memory write enable
- MEM_DIN  out  SIZE  memory write data
- MEM_DOUT  in  SIZE  memory read data, combinational from MEM_ADDR

## Operation
- Word index = ADDR[msb:3]; byte offset = ADDR[2:0].
- Loads:
  - FUNCT3 000 LB, 001 LH, 010 LW, 011 LD sign-extend.
  - FUNCT3 100 LBU, 101 LHU, 110 LWU zero-extend.
  - FUNCT3 111 is illegal.
- Stores:
  - FUNCT3 000 SB, 001 SH, 010 SW, 011 SD.
  - FUNCT3 1xx is illegal.
- Alignment rules: half needs offset[0]=0; word needs offset[1:0]=0; double needs offset=0. Any violation is misaligned.
- Little-endian byte lanes: byte k of the word is bits [8k+7:8k].
- FSM states:
  - IDLE: READY=1. On REQ, latch STORE, FUNCT3, ADDR and WDATA. If illegal or misaligned, go to RESP with ERR=1. Otherwise go to ACCESS.
  - ACCESS: MEM_ADDR = latched word index.
    - Load: extract and extend MEM_DOUT into RDATA, go to RESP.
    - SD: MEM_WE=1, MEM_DIN=WDATA, go to RESP.
    - Sub-word store: register MEM_DOUT with the addressed lanes replaced by WDATA's low bytes, go to WRITE.
  - WRITE: MEM_WE=1, MEM_DIN = merged word, go to RESP.
  - RESP: DONE=1; ERR valid; go to IDLE.
- REQ outside IDLE is ignored; the core must hold REQ until it sees READY.
- An erroneous access never asserts MEM_WE, and RDATA keeps its previous value.
- MEM_WE is asserted only in ACCESS (SD only) and WRITE.

## Timing
- Reset values: state=IDLE, READY=1, DONE=0, ERR=0, RDATA=0, MEM_WE=0, MEM_ADDR=0, MEM_DIN=0.
- Latency counts from the REQ-accept edge (cycle 0) to DONE high:
  - load: cycle 2
  - SD: cycle 2
  - SB/SH/SW: cycle 3
  - error: cycle 1
- READY is low from cycle 1 through the DONE cycle. Back-to-back requests are possible, with a new REQ accepted in the cycle after DONE.
- The memory write occurs on the rising edge that ends the MEM_WE cycle.
- RST_N asserted mid-operation: all outputs return to reset values immediately, and any pending write is dropped.
  - If reset arrives before the WRITE-state edge, memory is unchanged.
- Word index arithmetic has no wrap: the ADDR width spans exactly N words.

## Structure
- Shared package lsu_pkg:
  - FUNCT3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - FSM state enum (IDLE, ACCESS, WRITE, RESP).
- One combinational sub-module, lsu_lane, provides:
  - byte-enable generation from FUNCT3 and offset;
  - load extract and extend;
  - store merge.
- The top level holds the FSM, latched request registers, the RDATA register and the merge register.

## Test plan
- Memory word 16 = 0x2DB. LD at ADDR 128 → DONE at cycle 2, RDATA=0x00000000000002DB, ERR=0, MEM_WE never 1.
- Word 16 = 0x2DB. LB at ADDR 128 → RDATA=0xFFFFFFFFFFFFFFDB. LBU at ADDR 128 → RDATA=0x00000000000000DB.
- Word 16 = 0x2DB. SB with WDATA 0xAA at ADDR 130 → one MEM_WE cycle in WRITE with MEM_DIN=0x0000000000AA02DB, DONE at cycle 3; a following LD reads 0xAA02DB.
- LW at ADDR 130, and SD with FUNCT3 100 → DONE at cycle 1 with ERR=1, MEM_WE stays 0, RDATA unchanged.
- SH with WDATA 0x1234 at ADDR 8, with RST_N pulsed low while in WRITE → outputs go to reset values, word 1 is unchanged, READY=1.
- REQ held high continuously with alternating LD/SD → each accepted only in IDLE, one DONE per request, no lost or duplicated accesses.
